// File: rtl/npc_pkg.sv
// Shared execute-stage definitions: ALU op bit positions and the exu_ctrl state encoding.
package npc_pkg;

    localparam int ALU_OP_W   = 10;
    localparam int ALU_OP_ADD = 0;
    localparam int ALU_OP_MUL = 1;

    typedef enum logic [1:0] {
        EXU_IDLE = 2'd0,
        EXU_MUL  = 2'd1,
        EXU_DONE = 2'd2
    } exu_state_e;

endpackage

// File: rtl/exu_ctrl.sv
// Execute-stage sequencer: owns the shared add-only ALU, runs ADD/unknown ops in one
// pass and MUL as a DATA_WIDTH-step shift-add loop, and registers the write-back tuple.
module exu_ctrl
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_OP_W-1:0]   aluOp,
    input  logic [DATA_WIDTH-1:0] aluSrc1,
    input  logic [DATA_WIDTH-1:0] aluSrc2,
    input  logic                  d_regW,
    input  logic [ADDR_WIDTH-1:0] d_regAddr,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_src1,
    output logic [DATA_WIDTH-1:0] alu_src2,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  e_regW,
    output logic [ADDR_WIDTH-1:0] e_regAddr,
    output logic [DATA_WIDTH-1:0] e_regData
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    exu_state_e            state_q,     state_d;
    logic [CNT_W-1:0]      counter_q,   counter_d;
    logic [DATA_WIDTH-1:0] acc_q,       acc_d;
    logic [DATA_WIDTH-1:0] mcand_q,     mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q,    mplier_d;
    logic                  e_regW_q,    e_regW_d;
    logic [ADDR_WIDTH-1:0] e_regAddr_q, e_regAddr_d;
    logic [DATA_WIDTH-1:0] e_regData_q, e_regData_d;
    logic                  accept;

    assign in_ready  = (state_q == EXU_IDLE) || ((state_q == EXU_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == EXU_DONE);
    assign e_regW    = e_regW_q;
    assign e_regAddr = e_regAddr_q;
    assign e_regData = e_regData_q;

    // Next-state, datapath updates and ALU port steering.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d     = state_q;
        counter_d   = counter_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        e_regW_d    = e_regW_q;
        e_regAddr_d = e_regAddr_q;
        e_regData_d = e_regData_q;
        alu_op      = '0;
        alu_src1    = '0;
        alu_src2    = '0;

        case (state_q)
            EXU_IDLE, EXU_DONE: begin
                // A consumed tuple with nothing new behind it drops back to idle.
                if (state_q == EXU_DONE && out_ready) begin
                    state_d = EXU_IDLE;
                end
                if (accept) begin
                    e_regW_d    = d_regW;
                    e_regAddr_d = d_regAddr;
                    if (aluOp[ALU_OP_MUL]) begin
                        acc_d     = '0;
                        mcand_d   = aluSrc1;
                        mplier_d  = aluSrc2;
                        counter_d = '0;
                        state_d   = EXU_MUL;
                    end else begin
                        // Single pass: the sibling ALU yields 0 for reserved ops.
                        alu_op      = aluOp;
                        alu_src1    = aluSrc1;
                        alu_src2    = aluSrc2;
                        e_regData_d = alu_result;
                        state_d     = EXU_DONE;
                    end
                end
            end
            EXU_MUL: begin
                alu_op[ALU_OP_ADD] = 1'b1;
                alu_src1           = acc_q;
                alu_src2           = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                counter_d = counter_q + CNT_W'(1);
                // Fixed DATA_WIDTH iterations, no early exit on a zero multiplier.
                if (counter_q == CNT_LAST) begin
                    // NOTE: blocking assignments here read acc_d as already updated above.
                    e_regData_d = acc_d;
                    state_d     = EXU_DONE;
                end
            end
            default: state_d = EXU_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath registers are plain flops, so resetting them is cheap and keeps outputs defined.
            state_q     <= EXU_IDLE;
            counter_q   <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            e_regW_q    <= 1'b0;
            e_regAddr_q <= '0;
            e_regData_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q     <= state_d;
            counter_q   <= counter_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            e_regW_q    <= e_regW_d;
            e_regAddr_q <= e_regAddr_d;
            e_regData_q <= e_regData_d;
        end
    end

endmodule

// File: tb/tb_exu_ctrl.sv
// Directed testbench for exu_ctrl with a behavioural add-only ALU beside it.
module tb_exu_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [9:0]    aluOp;
    logic [DW-1:0] aluSrc1;
    logic [DW-1:0] aluSrc2;
    logic          d_regW;
    logic [AW-1:0] d_regAddr;
    logic [9:0]    alu_op;
    logic [DW-1:0] alu_src1;
    logic [DW-1:0] alu_src2;
    logic [DW-1:0] alu_result;
    logic          out_valid;
    logic          out_ready;
    logic          e_regW;
    logic [AW-1:0] e_regAddr;
    logic [DW-1:0] e_regData;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Sibling add-only ALU: adds when bit0 is set, otherwise 0.
    assign alu_result = alu_op[0] ? (alu_src1 + alu_src2) : '0;

    exu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .aluOp      (aluOp),
        .aluSrc1    (aluSrc1),
        .aluSrc2    (aluSrc2),
        .d_regW     (d_regW),
        .d_regAddr  (d_regAddr),
        .alu_op     (alu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .e_regW     (e_regW),
        .e_regAddr  (e_regAddr),
        .e_regData  (e_regData)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic w, input logic [AW-1:0] addr);
        in_valid  = 1'b1;
        aluOp     = op;
        aluSrc1   = a;
        aluSrc2   = b;
        d_regW    = w;
        d_regAddr = addr;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        aluOp     = '0;
        aluSrc1   = '0;
        aluSrc2   = '0;
        d_regW    = 1'b0;
        d_regAddr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        out_ready = 1'b1;
        cyc();
        cyc();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (e_regW !== 1'b0) begin fails++; $display("FAIL reset_e_regW: got %b want 0", e_regW); end
        tests++; if (e_regAddr !== 5'd0) begin fails++; $display("FAIL reset_e_regAddr: got %0d want 0", e_regAddr); end
        tests++; if (e_regData !== 32'd0) begin fails++; $display("FAIL reset_e_regData: got %h want 0", e_regData); end
        tests++; if (alu_op !== 10'd0) begin fails++; $display("FAIL reset_alu_op: got %h want 0", alu_op); end
        rst = 1'b0;
        cyc();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b0;
        drive(10'h001, 32'd5, 32'd7, 1'b1, 5'd3);
        #1;
        tests++; if (alu_op !== 10'h001) begin fails++; $display("FAIL add_alu_op: got %h want 001", alu_op); end
        tests++; if (alu_src1 !== 32'd5 || alu_src2 !== 32'd7) begin fails++; $display("FAIL add_alu_src: got %0d,%0d want 5,7", alu_src1, alu_src2); end
        cyc();
        idle_inputs();
        #1;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
        tests++; if (e_regData !== 32'd12) begin fails++; $display("FAIL add_e_regData: got %0d want 12", e_regData); end
        tests++; if (e_regAddr !== 5'd3 || e_regW !== 1'b1) begin fails++; $display("FAIL add_e_reg: got addr %0d w %b want 3 1", e_regAddr, e_regW); end
        tests++; if (alu_op !== 10'd0 || alu_src1 !== 32'd0) begin fails++; $display("FAIL add_alu_idle: got %h %h want 0 0", alu_op, alu_src1); end
        out_ready = 1'b1;
        cyc();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_retire: got %b want 0", out_valid); end
    endtask

    task automatic test_mul(input string name, input logic [9:0] op, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] expv);
        out_ready = 1'b1;
        drive(op, a, b, 1'b1, 5'd9);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_accept_ready: got %b want 1", name, in_ready); end
        cyc();
        idle_inputs();
        #1;
        tests++; if (alu_op !== 10'h001 || alu_src1 !== 32'd0 || alu_src2 !== a) begin
            fails++; $display("FAIL %s_first_iter_alu: got %h %h %h want 001 0 %h", name, alu_op, alu_src1, alu_src2, a);
        end
        for (int i = 0; i < DW; i++) begin
            tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                fails++; $display("FAIL %s_busy_cycle%0d: got ready %b valid %b want 0 0", name, i, in_ready, out_valid);
            end
            cyc();
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_out_valid: got %b want 1", name, out_valid); end
        tests++; if (e_regData !== expv) begin fails++; $display("FAIL %s_e_regData: got %h want %h", name, e_regData, expv); end
        tests++; if (e_regAddr !== 5'd9 || e_regW !== 1'b1) begin fails++; $display("FAIL %s_e_reg: got addr %0d w %b want 9 1", name, e_regAddr, e_regW); end
        cyc();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_retire: got %b want 0", name, out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(10'h001, 32'd10, 32'd20, 1'b1, 5'd7);
        cyc();
        // Pending op offered while the tuple is stalled must be ignored.
        drive(10'h001, 32'd1, 32'd1, 1'b1, 5'd8);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++; $display("FAIL hold%0d_handshake: got valid %b ready %b want 1 0", i, out_valid, in_ready);
            end
            tests++; if (e_regData !== 32'd30 || e_regAddr !== 5'd7 || e_regW !== 1'b1) begin
                fails++; $display("FAIL hold%0d_tuple: got %0d addr %0d w %b want 30 7 1", i, e_regData, e_regAddr, e_regW);
            end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        cyc();
        tests++; if (out_valid !== 1'b1 || e_regData !== 32'd2 || e_regAddr !== 5'd8) begin
            fails++; $display("FAIL b2b_first: got valid %b data %0d addr %0d want 1 2 8", out_valid, e_regData, e_regAddr);
        end
        drive(10'h001, 32'd3, 32'd4, 1'b0, 5'd11);
        cyc();
        tests++; if (out_valid !== 1'b1 || e_regData !== 32'd7 || e_regAddr !== 5'd11 || e_regW !== 1'b0) begin
            fails++; $display("FAIL b2b_second: got valid %b data %0d addr %0d w %b want 1 7 11 0", out_valid, e_regData, e_regAddr, e_regW);
        end
        idle_inputs();
        cyc();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        drive(10'h002, 32'd6, 32'd7, 1'b1, 5'd9);
        cyc();
        idle_inputs();
        for (int i = 0; i < 10; i++) cyc();
        tests++; if (dut.counter_q !== 5'd10) begin fails++; $display("FAIL midmul_counter: got %0d want 10", dut.counter_q); end
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || e_regW !== 1'b0 || e_regAddr !== 5'd0 || e_regData !== 32'd0) begin
            fails++; $display("FAIL midmul_reset_tuple: got %b %b %0d %h want 0 0 0 0", out_valid, e_regW, e_regAddr, e_regData);
        end
        tests++; if (alu_op !== 10'd0 || alu_src1 !== 32'd0 || alu_src2 !== 32'd0) begin
            fails++; $display("FAIL midmul_reset_alu: got %h %h %h want 0 0 0", alu_op, alu_src1, alu_src2);
        end
        cyc();
        rst = 1'b0;
        cyc();
        drive(10'h001, 32'd2, 32'd3, 1'b1, 5'd1);
        cyc();
        idle_inputs();
        #1;
        tests++; if (out_valid !== 1'b1 || e_regData !== 32'd5) begin
            fails++; $display("FAIL post_reset_add: got valid %b data %0d want 1 5", out_valid, e_regData);
        end
        cyc();
    endtask

    task automatic test_reserved();
        out_ready = 1'b1;
        drive(10'h004, 32'd9, 32'd9, 1'b1, 5'd4);
        cyc();
        idle_inputs();
        #1;
        tests++; if (out_valid !== 1'b1 || e_regData !== 32'd0) begin
            fails++; $display("FAIL reserved_data: got valid %b data %0d want 1 0", out_valid, e_regData);
        end
        tests++; if (e_regW !== 1'b1 || e_regAddr !== 5'd4) begin
            fails++; $display("FAIL reserved_reg: got w %b addr %0d want 1 4", e_regW, e_regAddr);
        end
        cyc();
        test_mul("mul_op3", 10'h003, 32'd9, 32'd9, 32'd81);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_mul("mul_6x7", 10'h002, 32'd6, 32'd7, 32'd42);
        test_mul("mul_ffx2", 10'h002, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        test_mul("mul_wrap", 10'h002, 32'h0001_0000, 32'h0001_0000, 32'd0);
        test_back_to_back();
        test_reset_mid_mul();
        test_reserved();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
